action_dispatcher: RTL and testbench

Sits directly upstream of the primitive executor. Accepts one match result per packet, reads that action's table entry from the shared SRAM to get the primitive program's start address, and runs the executor with a four-phase start/done handshake. Passes the packet descriptor downstream once the program has finished, or immediately if nothing has to run. Keeps saturating dispatch and skip counters.

---
 rtl/action_dispatcher_pkg.sv | 20 ++
 rtl/action_dispatcher_sat_counter16.sv | 32 +++
 rtl/action_dispatcher.sv | 167 ++++++++++++++++
 tb/tb_action_dispatcher.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/action_dispatcher_pkg.sv
// action_dispatcher shared definitions:
// FSM encodings, table-entry fields, constants.
package action_dispatcher_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOOKUP    = 3'd1;
    localparam logic [2:0] ST_READ      = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RELEASE   = 3'd4;
    localparam logic [2:0] ST_OUTPUT    = 3'd5;

    localparam int ENTRY_EN      = 31;
    localparam int ENTRY_ADDR_HI = 23;
    localparam int ENTRY_ADDR_LO = 0;

    localparam logic        TRUE      = 1'b1;
    localparam logic        FALSE     = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/action_dispatcher_sat_counter16.sv
// sat_counter16: 16-bit event counter that
// sticks at 16'hFFFF instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: step on enable unless already full
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/action_dispatcher.sv
// action_dispatcher: looks up an action's program address
// in SRAM and runs the primitive executor via start/done.
module action_dispatcher
    import action_dispatcher_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8,
    parameter int META_W = 32,
    parameter logic [ADDR_W-1:0] TABLE_BASE = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              match_valid_i,
    output logic              match_ready_o,
    input  logic              match_hit_i,
    input  logic [ID_W-1:0]   match_action_id_i,
    input  logic [META_W-1:0] match_meta_i,
    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [3:0]        sram_sel_o,
    input  logic [DATA_W-1:0] sram_data_i,
    output logic              exec_start_o,
    output logic [ADDR_W-1:0] exec_start_addr_o,
    input  logic              exec_done_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [META_W-1:0] out_meta_o,
    output logic              out_executed_o,
    output logic              out_error_o,
    output logic [15:0]       dispatch_cnt_o,
    output logic [15:0]       skip_cnt_o
);

    logic [2:0]        state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [META_W-1:0] meta_q, meta_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic              executed_q, executed_d;
    logic              error_q, error_d;
    logic              skip_inc;
    logic              disp_inc;
    logic [ADDR_W-1:0] table_addr;
    logic              unused_data;

    // One word per entry; wraps modulo the address width
    assign table_addr = TABLE_BASE + ADDR_W'({id_q, 2'b00});

    // Only the enable bit, low address bits and pointer matter
    assign unused_data = ^sram_data_i;

    // Next-state and datapath for the dispatch sequence
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        meta_d       = meta_q;
        start_addr_d = start_addr_q;
        executed_d   = executed_q;
        error_d      = error_q;
        skip_inc     = FALSE;
        disp_inc     = FALSE;
        unique case (state_q)
            ST_IDLE: begin
                if (match_valid_i) begin
                    id_d       = match_action_id_i;
                    meta_d     = match_meta_i;
                    executed_d = FALSE;
                    error_d    = FALSE;
                    if (match_hit_i) begin
                        state_d = ST_LOOKUP;
                    end else begin
                        skip_inc = TRUE;
                        state_d  = ST_OUTPUT;
                    end
                end
            end
            ST_LOOKUP: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                if (!sram_data_i[ENTRY_EN]) begin
                    skip_inc = TRUE;
                    state_d  = ST_OUTPUT;
                end else if (sram_data_i[1:0] != 2'b00) begin
                    error_d  = TRUE;
                    skip_inc = TRUE;
                    state_d  = ST_OUTPUT;
                end else begin
                    start_addr_d = ADDR_W'(
                        sram_data_i[ENTRY_ADDR_HI:ENTRY_ADDR_LO]);
                    disp_inc     = TRUE;
                    state_d      = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (exec_done_i) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!exec_done_i) begin
                    executed_d = TRUE;
                    state_d    = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched packet fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            meta_q       <= '0;
            start_addr_q <= '0;
            executed_q   <= FALSE;
            error_q      <= FALSE;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            meta_q       <= meta_d;
            start_addr_q <= start_addr_d;
            executed_q   <= executed_d;
            error_q      <= error_d;
        end
    end

    assign match_ready_o = (state_q == ST_IDLE) ? TRUE : FALSE;

    assign sram_ce_o   = (state_q == ST_LOOKUP);
    assign sram_we_o   = FALSE;
    assign sram_sel_o  = sram_ce_o ? 4'b1111 : 4'b0000;
    assign sram_addr_o = sram_ce_o ? table_addr
                                   : ADDR_W'(ZERO_WORD);

    assign exec_start_o      = (state_q == ST_WAIT_DONE);
    assign exec_start_addr_o = start_addr_q;

    assign out_valid_o    = (state_q == ST_OUTPUT);
    assign out_meta_o     = meta_q;
    assign out_executed_o = executed_q;
    assign out_error_o    = error_q;

    sat_counter16 u_dispatch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (disp_inc),
        .cnt_o (dispatch_cnt_o)
    );

    sat_counter16 u_skip_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (skip_inc),
        .cnt_o (skip_cnt_o)
    );

endmodule

// File: tb/tb_action_dispatcher.sv
// Bench for action_dispatcher: SRAM and executor
// responders, vector table, random traffic.
module tb_action_dispatcher;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        match_valid_i = 1'b0;
    logic        match_ready_o;
    logic        match_hit_i = 1'b0;
    logic [7:0]  match_action_id_i = '0;
    logic [31:0] match_meta_i = '0;
    logic        sram_ce_o;
    logic        sram_we_o;
    logic [31:0] sram_addr_o;
    logic [3:0]  sram_sel_o;
    logic [31:0] sram_data_i;
    logic        exec_start_o;
    logic [31:0] exec_start_addr_o;
    logic        exec_done_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_meta_o;
    logic        out_executed_o;
    logic        out_error_o;
    logic [15:0] dispatch_cnt_o;
    logic [15:0] skip_cnt_o;

    logic        sat_inc = 1'b0;
    logic [15:0] sat_cnt;

    int checks = 0;
    int errors = 0;
    int exp_skip = 0;
    int exp_disp = 0;
    int exec_delay = 1;
    int ecnt = 0;
    logic [31:0] tbl [256];

    typedef struct {
        bit        hit;
        bit [7:0]  id;
        bit [31:0] meta;
        bit [31:0] entry;
        int        delay;
        int        rdy_wait;
        bit        exp_exec;
        bit        exp_err;
        int        exp_lat;
        int        exp_starts;
    } vec_t;

    vec_t vecs [9];

    action_dispatcher dut (
        .clk               (clk),
        .rst               (rst),
        .match_valid_i     (match_valid_i),
        .match_ready_o     (match_ready_o),
        .match_hit_i       (match_hit_i),
        .match_action_id_i (match_action_id_i),
        .match_meta_i      (match_meta_i),
        .sram_ce_o         (sram_ce_o),
        .sram_we_o         (sram_we_o),
        .sram_addr_o       (sram_addr_o),
        .sram_sel_o        (sram_sel_o),
        .sram_data_i       (sram_data_i),
        .exec_start_o      (exec_start_o),
        .exec_start_addr_o (exec_start_addr_o),
        .exec_done_i       (exec_done_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_meta_o        (out_meta_o),
        .out_executed_o    (out_executed_o),
        .out_error_o       (out_error_o),
        .dispatch_cnt_o    (dispatch_cnt_o),
        .skip_cnt_o        (skip_cnt_o)
    );

    sat_counter16 u_sat (
        .clk   (clk),
        .rst   (rst),
        .inc_i (sat_inc),
        .cnt_o (sat_cnt)
    );

    always #5 clk = ~clk;

    // SRAM: data one cycle after address, junk otherwise
    always @(posedge clk) begin
        if (sram_ce_o)
            sram_data_i <= tbl[sram_addr_o[9:2]];
        else
            sram_data_i <= 32'hDEAD_BEEF;
    end

    // Executor: done after exec_delay start cycles,
    // drops the cycle after start falls
    always @(posedge clk) begin
        if (!exec_start_o) begin
            ecnt        <= 0;
            exec_done_i <= 1'b0;
        end else begin
            ecnt <= ecnt + 1;
            if (ecnt + 1 >= exec_delay)
                exec_done_i <= 1'b1;
        end
    end

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, exp);
        end
    endtask

    function automatic void predict(
        input bit hit, input bit [31:0] e, input int d,
        output bit ex, output bit er,
        output int lat, output int st);
        ex = 0; er = 0; st = 0;
        if (!hit) begin
            lat = 1;
        end else if (!e[31]) begin
            lat = 3;
        end else if (e[1:0] != 2'b00) begin
            er = 1; lat = 3;
        end else begin
            ex = 1; lat = 6 + d; st = d + 1;
        end
    endfunction

    task automatic send(input vec_t v);
        int lat;
        int ce_n = 0;
        int st_n = 0;
        bit bus_bad = 0;
        bit sa_bad = 0;
        bit bp_bad = 0;
        logic [31:0] exp_addr;
        logic [31:0] exp_sa;
        exp_addr = 32'h1000 + {22'd0, v.id, 2'b00};
        exp_sa = {8'd0, v.entry[23:0]};
        tbl[v.id] = v.entry;
        exec_delay = v.delay;
        chk("ready_idle", match_ready_o, 1);
        match_valid_i = 1'b1;
        match_hit_i = v.hit;
        match_action_id_i = v.id;
        match_meta_i = v.meta;
        @(negedge clk);
        match_valid_i = 1'b0;
        match_hit_i = 1'b0;
        match_action_id_i = '0;
        match_meta_i = '0;
        for (lat = 1; lat < 300; lat++) begin
            if (sram_we_o) bus_bad = 1;
            if (sram_ce_o) begin
                ce_n++;
                if (sram_sel_o !== 4'hF ||
                    sram_addr_o !== exp_addr)
                    bus_bad = 1;
            end else if (sram_sel_o !== 4'h0 ||
                         sram_addr_o !== 32'h0) begin
                bus_bad = 1;
            end
            if (exec_start_o) begin
                st_n++;
                if (exec_start_addr_o !== exp_sa)
                    sa_bad = 1;
            end
            if (out_valid_o) break;
            @(negedge clk);
        end
        chk("out_latency", lat, v.exp_lat);
        chk("out_meta", out_meta_o, v.meta);
        chk("out_executed", out_executed_o, v.exp_exec);
        chk("out_error", out_error_o, v.exp_err);
        chk("ready_busy", match_ready_o, 0);
        chk("sram_reads", ce_n, v.hit ? 1 : 0);
        chk("sram_bus_bad", bus_bad, 0);
        chk("start_cycles", st_n, v.exp_starts);
        chk("start_addr_bad", sa_bad, 0);
        match_valid_i = 1'b1;
        match_meta_i = 32'h0BAD_0BAD;
        repeat (v.rdy_wait) begin
            @(negedge clk);
            if (!out_valid_o || match_ready_o ||
                out_meta_o !== v.meta ||
                out_executed_o !== v.exp_exec ||
                out_error_o !== v.exp_err)
                bp_bad = 1;
        end
        match_valid_i = 1'b0;
        match_meta_i = '0;
        if (v.rdy_wait > 0)
            chk("backpressure_bad", bp_bad, 0);
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk("valid_after_hs", out_valid_o, 0);
        if (v.exp_exec) exp_disp++;
        else exp_skip++;
        if (exp_disp > 65535) exp_disp = 65535;
        if (exp_skip > 65535) exp_skip = 65535;
        chk("skip_cnt", skip_cnt_o, exp_skip);
        chk("dispatch_cnt", dispatch_cnt_o, exp_disp);
    endtask

    initial begin
        vec_t v;
        bit ex, er;
        int lat, st;
        logic [31:0] r;

        for (int i = 0; i < 256; i++) tbl[i] = '0;
        vecs[0] = '{0, 8'd5, 32'hCAFE_0001, 32'h0,
                    0, 0, 0, 0, 1, 0};
        vecs[1] = '{1, 8'd3, 32'h1111_0003, 32'h8000_0040,
                    6, 10, 1, 0, 12, 7};
        vecs[2] = '{1, 8'd7, 32'h2222_0007, 32'h0000_0040,
                    1, 0, 0, 0, 3, 0};
        vecs[3] = '{1, 8'd9, 32'h3333_0009, 32'h8000_0042,
                    1, 2, 0, 1, 3, 0};
        vecs[4] = '{1, 8'd255, 32'h4444_00FF, 32'h80FF_FFFC,
                    1, 0, 1, 0, 7, 2};
        vecs[5] = '{1, 8'd0, 32'h5555_0000, 32'h8000_0001,
                    1, 0, 0, 1, 3, 0};
        vecs[6] = '{1, 8'd1, 32'h6666_0001, 32'h7FFF_FFFF,
                    1, 0, 0, 0, 3, 0};
        vecs[7] = '{1, 8'd2, 32'h7777_0002, 32'hFF12_3400,
                    3, 1, 1, 0, 9, 4};
        vecs[8] = '{0, 8'd200, 32'hFFFF_FFFF, 32'h8000_0000,
                    1, 0, 0, 0, 1, 0};

        repeat (3) @(negedge clk);
        chk("rst_ready", match_ready_o, 1);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_ce", sram_ce_o, 0);
        chk("rst_sel", sram_sel_o, 0);
        chk("rst_addr", sram_addr_o, 0);
        chk("rst_start", exec_start_o, 0);
        chk("rst_start_addr", exec_start_addr_o, 0);
        chk("rst_meta", out_meta_o, 0);
        chk("rst_skip", skip_cnt_o, 0);
        chk("rst_disp", dispatch_cnt_o, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) send(vecs[i]);

        for (int n = 0; n < 40; n++) begin
            v.hit = ($urandom_range(0, 3) != 0);
            v.id = 8'($urandom_range(0, 255));
            v.meta = $urandom;
            r = $urandom;
            case ($urandom_range(0, 3))
                0: v.entry = r & 32'h7FFF_FFFF;
                1: v.entry = r | 32'h8000_0001;
                default: v.entry = (r | 32'h8000_0000)
                                   & 32'hFFFF_FFFC;
            endcase
            v.delay = $urandom_range(1, 4);
            v.rdy_wait = $urandom_range(0, 2);
            predict(v.hit, v.entry, v.delay,
                    ex, er, lat, st);
            v.exp_exec = ex;
            v.exp_err = er;
            v.exp_lat = lat;
            v.exp_starts = st;
            send(v);
        end

        tbl[4] = 32'h8000_0100;
        exec_delay = 50;
        match_valid_i = 1'b1;
        match_hit_i = 1'b1;
        match_action_id_i = 8'd4;
        match_meta_i = 32'hABCD_0004;
        @(negedge clk);
        match_valid_i = 1'b0;
        match_hit_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("wait_start", exec_start_o, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_start", exec_start_o, 0);
        chk("arst_valid", out_valid_o, 0);
        chk("arst_skip", skip_cnt_o, 0);
        chk("arst_disp", dispatch_cnt_o, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_skip = 0;
        exp_disp = 0;
        @(negedge clk);
        chk("post_rst_ready", match_ready_o, 1);
        chk("post_rst_start", exec_start_o, 0);
        send(vecs[0]);
        send(vecs[1]);

        sat_inc = 1'b1;
        repeat (65534) @(negedge clk);
        chk("sat_fffe", sat_cnt, 16'hFFFE);
        repeat (3) @(negedge clk);
        chk("sat_hold", sat_cnt, 16'hFFFF);
        sat_inc = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
